xbar: RTL and testbench

- Registered 5x5 crossbar switch for the mesh NoC router datapath.
- Each output port independently forwards the flit of the one input port named by its one-hot select.
- Selects come from the router's switch allocator, so the crossbar does no arbitration.
- Port index convention: 0=Local, 1=North, 2=East, 3=South, 4=West.

---
 rtl/xbar.sv | 71 +++++++
 tb/tb_xbar.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/xbar.sv
// Registered NxN crossbar: each output forwards the input named by its one-hot
// select, one cycle later. Multi-bit selects blank the output and raise sel_err.
module xbar #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_PORTS  = 5
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]  data_in,
    input  logic [NUM_PORTS-1:0]             valid_in,
    input  logic [NUM_PORTS*NUM_PORTS-1:0]   out_sel,
    output logic [NUM_PORTS*DATA_WIDTH-1:0]  data_out,
    output logic [NUM_PORTS-1:0]             valid_out,
    output logic [NUM_PORTS-1:0]             sel_err
);

    logic [NUM_PORTS*DATA_WIDTH-1:0] data_next;
    logic [NUM_PORTS-1:0]            valid_next;
    logic [NUM_PORTS-1:0]            err_next;

    logic [NUM_PORTS*DATA_WIDTH-1:0] data_reg;
    logic [NUM_PORTS-1:0]            valid_reg;
    logic [NUM_PORTS-1:0]            err_reg;

    localparam logic [NUM_PORTS-1:0] SEL_ONE = {{(NUM_PORTS-1){1'b0}}, 1'b1};

    genvar gi;
    generate
        for (gi = 0; gi < NUM_PORTS; gi++) begin : g_out
            logic [NUM_PORTS-1:0]  sel;
            logic [DATA_WIDTH-1:0] or_data;
            logic                  or_valid;
            logic                  multi;

            assign sel   = out_sel[gi*NUM_PORTS +: NUM_PORTS];
            // Clearing the lowest set bit leaves something only if 2+ bits were set.
            assign multi = |(sel & (sel - SEL_ONE));

            // AND-OR mux: exact for one-hot selects, masked off below otherwise.
            always_comb begin
                or_data  = '0;
                or_valid = 1'b0;
                for (int i = 0; i < NUM_PORTS; i++) begin
                    or_data  = or_data | (data_in[i*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{sel[i]}});
                    or_valid = or_valid | (valid_in[i] & sel[i]);
                end
            end

            assign data_next[gi*DATA_WIDTH +: DATA_WIDTH] = multi ? '0 : or_data;
            assign valid_next[gi] = or_valid & ~multi;
            assign err_next[gi]   = multi;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_reg  <= '0;
            valid_reg <= '0;
            err_reg   <= '0;
        end else begin
            data_reg  <= data_next;
            valid_reg <= valid_next;
            err_reg   <= err_next;
        end
    end

    assign data_out  = data_reg;
    assign valid_out = valid_reg;
    assign sel_err   = err_reg;

endmodule

// File: tb/tb_xbar.sv
// Directed and short random checks of the registered 5x5 crossbar.
module tb_xbar;
    localparam int DW = 32;
    localparam int NP = 5;

    logic                 clk;
    logic                 rst_n;
    logic [NP*DW-1:0]     data_in;
    logic [NP-1:0]        valid_in;
    logic [NP*NP-1:0]     out_sel;
    logic [NP*DW-1:0]     data_out;
    logic [NP-1:0]        valid_out;
    logic [NP-1:0]        sel_err;

    int checks_cnt;
    int errors_cnt;

    xbar #(.DATA_WIDTH(DW), .NUM_PORTS(NP)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .data_in   (data_in),
        .valid_in  (valid_in),
        .out_sel   (out_sel),
        .data_out  (data_out),
        .valid_out (valid_out),
        .sel_err   (sel_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [NP*DW-1:0] obs, input logic [NP*DW-1:0] exp);
        checks_cnt++;
        if (obs !== exp) begin
            errors_cnt++;
            $display("FAIL %s got %h expected %h", tag, obs, exp);
        end
    endtask

    // Independent reference: count select bits, locate the chosen input.
    task automatic model(input logic [NP*DW-1:0] d, input logic [NP-1:0] v, input logic [NP*NP-1:0] s,
                         output logic [NP*DW-1:0] ed, output logic [NP-1:0] ev, output logic [NP-1:0] ee);
        logic [NP-1:0] f;
        ed = '0; ev = '0; ee = '0;
        for (int o = 0; o < NP; o++) begin
            f = s[o*NP +: NP];
            if ($countones(f) == 1) begin
                for (int i = 0; i < NP; i++)
                    if (f == (NP'(1) << i)) begin
                        ed[o*DW +: DW] = d[i*DW +: DW];
                        ev[o] = v[i];
                    end
            end else if ($countones(f) > 1) begin
                ee[o] = 1'b1;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [NP*DW-1:0] exp_d;
    logic [NP-1:0]    exp_v, exp_e;
    logic [NP*DW-1:0] hold_d;

    initial begin
        checks_cnt = 0;
        errors_cnt = 0;
        rst_n    = 1'b0;
        data_in  = '0;
        valid_in = '0;
        out_sel  = '0;
        #3;
        check("rst_data",  data_out, '0);
        check("rst_valid", {155'd0, valid_out}, '0);
        check("rst_err",   {155'd0, sel_err}, '0);
        tick();
        #2 rst_n = 1'b1;
        tick(); tick();
        check("idle_data",  data_out, '0);
        check("idle_valid", {155'd0, valid_out}, '0);

        // Permutation: output o takes input (o+1)%5.
        for (int i = 0; i < NP; i++) data_in[i*DW +: DW] = 32'hA000_0000 + 32'(i);
        valid_in = 5'b11111;
        for (int o = 0; o < NP; o++) out_sel[o*NP +: NP] = 5'(1) << ((o + 1) % NP);
        #2 check("no_comb_path", data_out, '0);
        tick();
        for (int o = 0; o < NP; o++)
            check($sformatf("perm_d%0d", o), {128'd0, data_out[o*DW +: DW]}, {128'd0, 32'hA000_0000 + 32'((o + 1) % NP)});
        check("perm_valid", {155'd0, valid_out}, {155'd0, 5'b11111});
        check("perm_err",   {155'd0, sel_err}, '0);
        $display("txn perm data_out=%h", data_out);

        // Multicast of input 2.
        data_in[2*DW +: DW] = 32'hDEAD_BEEF;
        for (int o = 0; o < NP; o++) out_sel[o*NP +: NP] = 5'b00100;
        tick();
        check("mcast_data",  data_out, {5{32'hDEAD_BEEF}});
        check("mcast_valid", {155'd0, valid_out}, {155'd0, 5'b11111});
        $display("txn mcast data_out=%h", data_out);

        // Invalid input still passes data.
        out_sel = '0;
        out_sel[3*NP +: NP] = 5'b00001;
        data_in[0 +: DW] = 32'h1234_5678;
        valid_in = 5'b11110;
        tick();
        check("inv_data3",  {128'd0, data_out[3*DW +: DW]}, {128'd0, 32'h1234_5678});
        check("inv_valid",  {155'd0, valid_out}, '0);
        check("inv_idle0",  {128'd0, data_out[0 +: DW]}, '0);
        $display("txn invalid data_out=%h valid_out=%b", data_out, valid_out);

        // Select error on output 1, others straight through.
        for (int i = 0; i < NP; i++) data_in[i*DW +: DW] = 32'hA000_0000 + 32'(i);
        valid_in = 5'b11111;
        for (int o = 0; o < NP; o++) out_sel[o*NP +: NP] = 5'(1) << o;
        out_sel[1*NP +: NP] = 5'b00011;
        tick();
        check("err_flag",  {155'd0, sel_err}, {155'd0, 5'b00010});
        check("err_valid", {155'd0, valid_out}, {155'd0, 5'b11101});
        check("err_data",  data_out, {32'hA000_0004, 32'hA000_0003, 32'hA000_0002, 32'h0, 32'hA000_0000});
        $display("txn selerr sel_err=%b", sel_err);
        out_sel[1*NP +: NP] = 5'b00010;
        tick();
        check("err_clear", {155'd0, sel_err}, '0);
        check("err_recov", {128'd0, data_out[1*DW +: DW]}, {128'd0, 32'hA000_0001});

        // Back-to-back random traffic against the reference model.
        for (int t = 0; t < 20; t++) begin
            for (int i = 0; i < NP; i++) data_in[i*DW +: DW] = $urandom;
            valid_in = 5'($urandom);
            for (int o = 0; o < NP; o++)
                out_sel[o*NP +: NP] = ($urandom_range(0, 3) == 0) ? 5'($urandom) : (5'(1) << $urandom_range(0, NP - 1));
            model(data_in, valid_in, out_sel, exp_d, exp_v, exp_e);
            tick();
            check($sformatf("rnd%0d_data", t),  data_out, exp_d);
            check($sformatf("rnd%0d_valid", t), {155'd0, valid_out}, {155'd0, exp_v});
            check($sformatf("rnd%0d_err", t),   {155'd0, sel_err}, {155'd0, exp_e});
            $display("txn rnd%0d sel=%h valid_out=%b sel_err=%b", t, out_sel, valid_out, sel_err);
        end

        // Async reset mid-cycle with traffic active.
        for (int o = 0; o < NP; o++) out_sel[o*NP +: NP] = 5'b00001;
        valid_in = 5'b11111;
        data_in[0 +: DW] = 32'hCAFE_F00D;
        tick();
        hold_d = data_out;
        check("pre_rst_data", hold_d, {5{32'hCAFE_F00D}});
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_data",  data_out, '0);
        check("async_rst_valid", {155'd0, valid_out}, '0);
        check("async_rst_err",   {155'd0, sel_err}, '0);
        out_sel = '0;
        tick();
        #2 rst_n = 1'b1;
        tick();
        check("post_rst_data",  data_out, '0);
        check("post_rst_valid", {155'd0, valid_out}, '0);

        $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
        $finish;
    end
endmodule
